// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall controller.
// The optional HAZARD_PERF_EN counters use sat_inc.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         WAIT_CNT_W = 16;
    localparam int         PERF_W     = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != {PERF_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational comparator between the ID sources and the EX/MEM destinations.
// It reports load-use hazards always, and plain RAW hazards only when forwarding is absent.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [4:0] id_src1,
    input  logic [4:0] id_src2,
    input  logic       id_two_src,
    input  logic       id_valid,
    input  logic [4:0] ex_dst,
    input  logic       ex_wb_en,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_dst,
    input  logic       mem_wb_en,
    output logic       load_use,
    output logic       raw
);

    logic w_use1;
    logic w_use2;
    logic w_ex_hit;
    logic w_mem_hit;

    // Register 0 is hardwired, so a match on it is never a real dependency.
    assign w_use1 = id_valid && (id_src1 != REG_ZERO);
    assign w_use2 = id_valid && id_two_src && (id_src2 != REG_ZERO);

    assign w_ex_hit  = ex_wb_en && ((w_use1 && (ex_dst == id_src1)) ||
                                    (w_use2 && (ex_dst == id_src2)));
    assign w_mem_hit = mem_wb_en && ((w_use1 && (mem_dst == id_src1)) ||
                                     (w_use2 && (mem_dst == id_src2)));

    assign load_use = ex_mem_read && w_ex_hit;
    assign raw      = (FWD_EN == 0) ? (w_ex_hit || w_mem_hit) : 1'b0;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: drives hold/flush/bubble for PC, IF/ID and ID/EX.
// Optional macro HAZARD_PERF_EN adds saturating performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic        id_valid,
    input  logic [4:0]  ex_dst,
    input  logic        ex_wb_en,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_dst,
    input  logic        mem_wb_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        hold_front,
    output logic        hold_all,
    output logic        bubble_id,
    output logic        flush_if,
    output logic        mem_err,
    output logic [1:0]  dbg_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cyc
`endif
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    state_t                r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic w_load_use;
    logic w_raw;
    logic w_hazard;
    logic w_mem_stall;
    logic w_run_eval;
    logic w_hold_front;
    logic w_hold_all;
    logic w_bubble_id;
    logic w_flush_if;
    logic w_mem_err;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_detect (
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .id_valid    (id_valid),
        .ex_dst      (ex_dst),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dst     (mem_dst),
        .mem_wb_en   (mem_wb_en),
        .load_use    (w_load_use),
        .raw         (w_raw)
    );

    assign w_hazard    = w_load_use || w_raw;
    // mem_req/mem_ready: an access completes in any cycle where both are high;
    // mem_req without mem_ready is a wait, and the request stays asserted until ready.
    assign w_mem_stall = mem_req && !mem_ready;
    // The cycle a wait ends is treated like a RUN cycle so held branches/hazards act at once.
    assign w_run_eval  = ((r_state == RUN) && !w_mem_stall) ||
                         ((r_state == MEM_WAIT) && mem_ready);

    always_comb begin
        w_hold_front = 1'b0;
        w_hold_all   = 1'b0;
        w_bubble_id  = 1'b0;
        w_flush_if   = 1'b0;
        w_mem_err    = 1'b0;
        if (!rst) begin
            if (r_state == ERR) begin
                w_hold_front = 1'b1;
                w_hold_all   = 1'b1;
                w_mem_err    = 1'b1;
            end else if (w_run_eval) begin
                if (branch_taken) begin
                    w_flush_if  = 1'b1;
                    w_bubble_id = 1'b1;
                end else if (w_hazard) begin
                    w_hold_front = 1'b1;
                    w_bubble_id  = 1'b1;
                end
            end else begin
                w_hold_front = 1'b1;
                w_hold_all   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == TIMEOUT_LAST) begin
                        r_state <= ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ERR:     r_state <= ERR;
                default: r_state <= RUN;
            endcase
        end
    end

    assign hold_front = w_hold_front;
    assign hold_all   = w_hold_all;
    assign bubble_id  = w_bubble_id;
    assign flush_if   = w_flush_if;
    assign mem_err    = w_mem_err;
    assign dbg_state  = r_state;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_perf_stall;
    logic [PERF_W-1:0] r_perf_flush;
    logic [PERF_W-1:0] r_perf_memwait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
            r_perf_memwait <= '0;
        end else begin
            r_perf_stall   <= sat_inc(r_perf_stall, w_hold_front);
            r_perf_flush   <= sat_inc(r_perf_flush, w_flush_if);
            r_perf_memwait <= sat_inc(r_perf_memwait, r_state != RUN);
        end
    end

    assign perf_stall_cyc   = r_perf_stall;
    assign perf_flush_cnt   = r_perf_flush;
    assign perf_memwait_cyc = r_perf_memwait;
`else
    // Without the counters the controller is unchanged.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (forwarding / no forwarding) share stimulus.
// Build with HAZARD_PERF_EN defined to also check the performance counters.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       id_two_src;
    logic       id_valid;
    logic [4:0] ex_dst;
    logic       ex_wb_en;
    logic       ex_mem_read;
    logic [4:0] mem_dst;
    logic       mem_wb_en;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic       hf_a, ha_a, bb_a, fl_a, me_a;
    logic       hf_b, ha_b, bb_b, fl_b, me_b;
    logic [1:0] st_a, st_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps_a, pf_a, pm_a, ps_b, pf_b, pm_b;
`endif

    int n_checks;
    int n_errors;

    // Reference model state, index 0 = forwarding instance, 1 = no-forwarding instance.
    int          m_mode[2];
    int          m_waited[2];
    int unsigned m_stall[2];
    int unsigned m_flush[2];
    int unsigned m_memwait[2];
    int          fwd_of[2];
    int          to_of[2];

    hazard_stall_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_valid(id_valid), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .hold_front(hf_a), .hold_all(ha_a),
        .bubble_id(bb_a), .flush_if(fl_a), .mem_err(me_a), .dbg_state(st_a)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(ps_a), .perf_flush_cnt(pf_a), .perf_memwait_cyc(pm_a)
`endif
    );

    hazard_stall_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(6)) dut_b (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_valid(id_valid), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .hold_front(hf_b), .hold_all(ha_b),
        .bubble_id(bb_b), .flush_if(fl_b), .mem_err(me_b), .dbg_state(st_b)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cyc(ps_b), .perf_flush_cnt(pf_b), .perf_memwait_cyc(pm_b)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control vector {hold_front, hold_all, bubble_id, flush_if, mem_err, state}.
    function automatic logic [6:0] model_out(input int d);
        logic       hz;
        logic [4:0] s;
        logic       hf, ha, bb, fl, me;
        hz = 1'b0;
        hf = 1'b0; ha = 1'b0; bb = 1'b0; fl = 1'b0; me = 1'b0;
        for (int i = 0; i < (id_two_src ? 2 : 1); i++) begin
            s = (i == 0) ? id_src1 : id_src2;
            if (id_valid && s != 5'd0) begin
                if (ex_mem_read && ex_wb_en && ex_dst == s) hz = 1'b1;
                if (fwd_of[d] == 0 && ((ex_wb_en && ex_dst == s) || (mem_wb_en && mem_dst == s)))
                    hz = 1'b1;
            end
        end
        if (rst) return 7'd0;
        if (m_mode[d] == 2) begin
            hf = 1'b1; ha = 1'b1; me = 1'b1;
        end else if ((m_mode[d] == 1 && !mem_ready) || (m_mode[d] == 0 && mem_req && !mem_ready)) begin
            hf = 1'b1; ha = 1'b1;
        end else if (branch_taken) begin
            fl = 1'b1; bb = 1'b1;
        end else if (hz) begin
            hf = 1'b1; bb = 1'b1;
        end
        return {hf, ha, bb, fl, me, 2'(m_mode[d])};
    endfunction

    // Advance the model by one clock edge with the inputs of the finished cycle.
    task automatic model_step(input int d);
        logic [6:0] o;
        o = model_out(d);
        if (o[6] && m_stall[d] != 32'hFFFF_FFFF) m_stall[d]++;
        if (o[3] && m_flush[d] != 32'hFFFF_FFFF) m_flush[d]++;
        if (m_mode[d] != 0 && m_memwait[d] != 32'hFFFF_FFFF) m_memwait[d]++;
        if (m_mode[d] == 1) begin
            if (mem_ready) m_mode[d] = 0;
            else if (m_waited[d] + 1 >= to_of[d]) m_mode[d] = 2;
            else m_waited[d]++;
        end else if (m_mode[d] == 0 && mem_req && !mem_ready) begin
            m_mode[d]   = 1;
            m_waited[d] = 0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_waited[d] = 0;
            m_stall[d] = 0; m_flush[d] = 0; m_memwait[d] = 0;
        end
    endtask

    // Scoreboard comparison
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/fwd"},   {25'd0, hf_a, ha_a, bb_a, fl_a, me_a, st_a}, {25'd0, model_out(0)});
        check({tag, "/nofwd"}, {25'd0, hf_b, ha_b, bb_b, fl_b, me_b, st_b}, {25'd0, model_out(1)});
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf(input string tag);
        check({tag, "/stall_a"},   ps_a, m_stall[0]);
        check({tag, "/flush_a"},   pf_a, m_flush[0]);
        check({tag, "/memwait_a"}, pm_a, m_memwait[0]);
        check({tag, "/stall_b"},   ps_b, m_stall[1]);
        check({tag, "/flush_b"},   pf_b, m_flush[1]);
        check({tag, "/memwait_b"}, pm_b, m_memwait[1]);
    endtask
`endif

    // Driver tasks: inputs change on the falling edge, outputs are sampled 1 time unit later.
    task automatic clr_in();
        id_src1 = 5'd0; id_src2 = 5'd0; id_two_src = 1'b0; id_valid = 1'b0;
        ex_dst = 5'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
        mem_dst = 5'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
`ifdef HAZARD_PERF_EN
        check_perf(tag);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int rdy_bias;

    initial begin
        n_checks = 0;
        n_errors = 0;
        fwd_of[0] = 1; fwd_of[1] = 0;
        to_of[0]  = 4; to_of[1]  = 6;
        model_reset();
        clr_in();
        rst = 1'b1;
        @(negedge clk);

        // Reset holds every output low even with active requests on the inputs.
        branch_taken = 1'b1; mem_req = 1'b1; id_valid = 1'b1; id_src1 = 5'd5;
        ex_dst = 5'd5; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        do_reset("reset_idle");
        clr_in();

        // lw r5 in EX, add r3,r5,r1 in ID: one bubble, then the load moves to MEM.
        ex_dst = 5'd5; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
        id_valid = 1'b1; id_src1 = 5'd5; id_src2 = 5'd1; id_two_src = 1'b1;
        step("load_use");
        ex_dst = 5'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
        mem_dst = 5'd5; mem_wb_en = 1'b1;
        step("after_bubble");
        mem_dst = 5'd0; mem_wb_en = 1'b0;
        step("resume");

        // A load to r0 never stalls.
        ex_dst = 5'd0; ex_wb_en = 1'b1; ex_mem_read = 1'b1; id_src1 = 5'd0;
        step("load_r0");

        // Taken branch overrides a simultaneous load-use hazard.
        ex_dst = 5'd5; id_src1 = 5'd5; branch_taken = 1'b1;
        step("branch_over_hazard");
        clr_in();
        step("idle");

        // Memory wait of three cycles, ready in the fourth.
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait");
        mem_ready = 1'b1;
        step("mem_done");
        clr_in();
        step("post_wait");

        // Same-cycle ready means no stall.
        mem_req = 1'b1; mem_ready = 1'b1;
        step("mem_fast");

        // Branch held through a wait is acted on in the completion cycle.
        mem_ready = 1'b0; branch_taken = 1'b1;
        step("wait_branch0");
        step("wait_branch1");
        mem_ready = 1'b1;
        step("wait_branch_done");
        clr_in();

        // RAW on r7 in MEM: src2 only matters when it is read.
        mem_dst = 5'd7; mem_wb_en = 1'b1; id_valid = 1'b1;
        id_src1 = 5'd2; id_src2 = 5'd7; id_two_src = 1'b0;
        step("raw_src2_unused");
        id_two_src = 1'b1;
        step("raw_src2_used");
        id_valid = 1'b0;
        step("raw_invalid");
        clr_in();

        // Memory never answers: both instances reach ERR and stay there.
        mem_req = 1'b1;
        for (int i = 0; i < 10; i++) step("timeout");
        mem_ready = 1'b1; branch_taken = 1'b1;
        step("err_sticky");
`ifdef HAZARD_PERF_EN
        check_perf("perf_directed");
`endif
        do_reset("reset_from_err");
        clr_in();
        step("after_reset");

        // Randomized traffic with slow/fast memory phases.
        rdy_bias = 7;
        for (int n = 0; n < 3000; n++) begin
            if (n % 60 == 0) rdy_bias = $urandom_range(1, 9);
            if ((m_mode[0] == 2 || m_mode[1] == 2) && $urandom_range(0, 7) == 0) begin
                do_reset("rand_reset");
            end
            id_src1      = 5'($urandom_range(0, 7));
            id_src2      = 5'($urandom_range(0, 7));
            id_two_src   = 1'($urandom_range(0, 1));
            id_valid     = ($urandom_range(0, 9) != 0);
            ex_dst       = 5'($urandom_range(0, 7));
            ex_wb_en     = 1'($urandom_range(0, 1));
            ex_mem_read  = 1'($urandom_range(0, 1));
            mem_dst      = 5'($urandom_range(0, 7));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = ($urandom_range(0, 2) == 0) || (m_mode[0] == 1) || (m_mode[1] == 1);
            mem_ready    = ($urandom_range(0, 9) < rdy_bias);
            step("random");
        end
`ifdef HAZARD_PERF_EN
        check_perf("perf_random");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage core. It watches the ID, EX and MEM stages and drives the hold/flush controls of the PC, IF/ID and ID/EX registers. It is the producer of the `flush` (bubble) request that the ID/EX stage register consumes. It resolves load-use and RAW hazards, taken-branch squashes and multi-cycle memory waits, with a watchdog on memory stalls.

## Interface
Parameters:
- `FWD_EN`, default 1: forwarding exists downstream. 1 means stall only on load-use; 0 means stall on any RAW against EX or MEM.
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before an error is flagged (range 1..65535).

Ports (the first two are already decided):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_src1`, `id_src2` in 5: source registers of the instruction in ID.
- `id_two_src` in 1: ID instruction reads `id_src2`.
- `id_valid` in 1: ID holds a real instruction.
- `ex_dst` in 5, `ex_wb_en` in 1, `ex_mem_read` in 1: ID/EX register outputs.
- `mem_dst` in 5, `mem_wb_en` in 1: EX/MEM register outputs.
- `branch_taken` in 1: EX resolved a taken branch this cycle.
- `mem_req` in 1, `mem_ready` in 1: MEM-stage data-memory access and its completion.
- `hold_front` out 1: PC and IF/ID keep their values.
- `hold_all` out 1: ID/EX, EX/MEM and MEM/WB keep their values.
- `bubble_id` out 1: ID/EX loads all zeros at the next edge.
- `flush_if` out 1: IF/ID loads NOP at the next edge.
- `mem_err` out 1: sticky memory-timeout flag.
- `perf_*` out 32 each: present only with the macro (see Configuration).

## Operation
- Register 0 never causes a hazard. A source is compared only if it is used: `id_src1` always, `id_src2` only when `id_two_src`. All comparisons require `id_valid`.
- Load-use hazard: `ex_mem_read && ex_wb_en && ex_dst == used src`.
- RAW hazard (only when FWD_EN=0): `ex_wb_en && ex_dst == src`, or `mem_wb_en && mem_dst == src`.
- FSM states: RUN, MEM_WAIT, ERR.
- RUN, evaluated in priority order:
  1. `mem_req && !mem_ready`: assert `hold_front` and `hold_all`, go to MEM_WAIT, clear the wait counter.
  2. `branch_taken`: assert `flush_if` and `bubble_id`; `hold_front` stays 0. This overrides any hazard, because the ID instruction is wrong-path.
  3. Hazard: assert `hold_front` and `bubble_id`.
  4. Otherwise all controls are 0.
- MEM_WAIT: `hold_front` and `hold_all` are 1; `bubble_id` and `flush_if` are 0. The wait counter increments each cycle.
  - When `mem_ready` is 1, return to RUN. That same cycle is evaluated with the RUN rules 2–4, so a branch or hazard held during the wait is acted on immediately.
  - If the counter reaches `MEM_TIMEOUT` while `mem_ready` is still 0, go to ERR.
- ERR: `hold_front` and `hold_all` are 1; `mem_err` is 1. Only `rst` leaves ERR.
- The wait counter is 16 bits wide and never wraps, because it is bounded by `MEM_TIMEOUT`.

## Timing
- Controls are combinational from the registered state and the current inputs, with zero-cycle latency. The consuming registers act at the next rising edge.
- A load-use hazard produces exactly one bubble. The next cycle, `ex_mem_read` is 0 because of that bubble, so the hazard clears. With FWD_EN=0, RAW stalls last until the producer leaves MEM: at most 2 cycles.
- A taken branch costs 2 squashed slots, delivered as a single-cycle flush.
- While `rst` is high, all outputs are forced to 0, state is RUN, and counters and `mem_err` are 0.
- Reset asserted during MEM_WAIT or ERR returns to RUN asynchronously.
- `mem_ready` asserted in the same cycle as `mem_req` means no stall.

## Configuration
- `HAZARD_PERF_EN` defined:
  - Adds `perf_stall_cyc`: cycles with `hold_front` set.
  - Adds `perf_flush_cnt`: count of `flush_if` pulses.
  - Adds `perf_memwait_cyc`: cycles spent in MEM_WAIT or ERR.
  - All three are 32-bit saturating at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent, and the logic is otherwise identical.

## Structure
- Shared package `hazard_pkg`: FSM state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2), the `REG_ZERO` constant, and the counter width constant.
- Sub-module `hazard_detect`: purely combinational source/destination comparator that outputs `load_use` and `raw`. It is instantiated once; the FSM lives in the top level.

## Test plan
- EX has lw to r5; ID has add r3,r5,r1 → exactly 1 cycle with `hold_front`=1 and `bubble_id`=1, then the pipeline resumes. Repeat with `ex_dst`=0 → no stall.
- `branch_taken`=1 together with a load-use hazard → `flush_if`=1, `bubble_id`=1, `hold_front`=0 for 1 cycle.
- `mem_req`=1 with `mem_ready` rising after 3 cycles → `hold_all`=1 for exactly 3 cycles, then RUN.
- MEM_TIMEOUT=4 and `mem_ready` held at 0 → enters ERR after 4 wait cycles with `mem_err`=1; `rst` pulse → all outputs 0.
- FWD_EN=0, MEM has `mem_dst`=r7 with wb, ID reads r7 as src2 with `id_two_src`=0 → no stall; with `id_two_src`=1 → 1 stall cycle.
- HAZARD_PERF_EN defined: after the scenarios above → `perf_stall_cyc`, `perf_flush_cnt` and `perf_memwait_cyc` match the expected counts; force saturation → counters hold at 0xFFFFFFFF.
